// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS core.
// The IF/ID bundle defined here is also consumed by the ID stage.
package pipe_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc4;
        logic              valid;
        logic              misalign;
    } if_id_t;

    localparam if_id_t IFID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc4:      '0,
        valid:    1'b0,
        misalign: 1'b0
    };

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register: reset > bubble > hold > load.
// Reused for IF/ID and later inter-stage registers.
module ifid_reg
    import pipe_pkg::*;
#(
    parameter type T      = if_id_t,
    parameter T    BUBBLE = IFID_BUBBLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bubble_i,
    input  logic hold_i,
    input  T     d_i,
    output T     q_o
);

    T q_q;
    T q_d;

    always_comb begin
        q_d = q_q;
        if (bubble_i) begin
            q_d = BUBBLE;
        end else if (!hold_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, drives the instruction port and fills IF/ID.
// Redirects squash the wrong-path fetch; there is no delay slot.
module instr_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WORD_W-1:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Redirect_en,
    input  logic [WORD_W-1:0] Redirect_Addr,
    output logic [WORD_W-1:0] Instr_Addr,
    input  logic [WORD_W-1:0] Inst,
    output logic [WORD_W-1:0] IFID_Instr,
    output logic [WORD_W-1:0] IFID_PC4,
    output logic              IFID_Valid,
    output logic              IFID_Misalign,
    output logic [WORD_W-1:0] Fetch_Count
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic              mis_q;
    logic              mis_d;
    logic [WORD_W-1:0] cnt_q;
    logic [WORD_W-1:0] cnt_d;

    logic   bubble;
    logic   load;
    if_id_t ifid_d;
    if_id_t ifid_q;

    assign bubble = Flush | Redirect_en;
    assign load   = ~bubble & ~Stall;

    // Redirect outranks Stall so a resolved branch is never lost.
    always_comb begin
        pc_d  = pc_q;
        mis_d = mis_q;
        if (Redirect_en) begin
            pc_d  = {Redirect_Addr[WORD_W-1:2], 2'b00};
            mis_d = |Redirect_Addr[1:0];
        end else if (!Stall) begin
            pc_d  = pc_q + PC_STEP;
            mis_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        ifid_d          = IFID_BUBBLE;
        ifid_d.instr    = Inst;
        ifid_d.pc4      = pc_q + 32'd4;
        ifid_d.valid    = 1'b1;
        ifid_d.misalign = mis_q;
    end

    ifid_reg #(
        .T      (if_id_t),
        .BUBBLE (IFID_BUBBLE)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (bubble),
        .hold_i   (Stall),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign Instr_Addr    = pc_q;
    assign IFID_Instr    = ifid_q.instr;
    assign IFID_PC4      = ifid_q.pc4;
    assign IFID_Valid    = ifid_q.valid;
    assign IFID_Misalign = ifid_q.misalign;
    assign Fetch_Count   = cnt_q;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
IF stage of the 5-stage MIPS pipeline. Owns the PC, drives the instruction-address port of the unified memory and latches the returned word into the IF/ID pipeline register. Takes stall/flush from the hazard unit and PC redirects (branch/jump) from EX. There is no branch delay slot: a redirect squashes the wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
PC_STEP, 4, PC increment per sequential fetch in bytes

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  synchronous, active-low reset
Stall  input  1  hold the PC and IF/ID contents
Flush  input  1  write a bubble into IF/ID
Redirect_en  input  1  taken branch/jump resolved in EX
Redirect_Addr  input  32  redirect target byte address
Instr_Addr  output  32  to memory instruction port (= PC, combinational)
Inst  input  32  from memory, valid in the same cycle as Instr_Addr
IFID_Instr  output  32  latched instruction
IFID_PC4  output  32  PC+4 of the latched instruction
IFID_Valid  output  1  IF/ID holds a real instruction
IFID_Misalign  output  1  latched fetch came from a misaligned redirect
Fetch_Count  output  32  count of instructions accepted into IF/ID

Behaviour:
- Reset (rst_n=0 at posedge): PC<=RESET_PC; IFID_Instr<=0 (NOP); IFID_PC4<=0; IFID_Valid<=0; IFID_Misalign<=0; Fetch_Count<=0; misalign flag<=0. Reset overrides all other inputs, including mid-redirect or mid-stall.
- Instr_Addr = PC at all times. There is no memory handshake: the memory is combinational, so fetch latency is 1 cycle (address at cycle N, IF/ID loaded at posedge ending cycle N).
- PC next-state priority: reset > Redirect_en > Stall > sequential.
  - Redirect: PC<={Redirect_Addr[31:2],2'b00}. The internal misalign flag <= |Redirect_Addr[1:0]. Redirect wins over a simultaneous Stall.
  - Stall: PC and misalign flag hold.
  - Sequential: PC<=PC+PC_STEP, modulo 2^32 (32'hFFFF_FFFC wraps to 0). Misalign flag<=0.
- IF/ID next-state priority: reset > (Flush or Redirect_en) > Stall > load.
  - Bubble: IFID_Instr<=0, IFID_PC4<=0, IFID_Valid<=0, IFID_Misalign<=0.
  - Stall: all IF/ID fields hold.
  - Load: IFID_Instr<=Inst; IFID_PC4<=PC+4 (wrapping); IFID_Valid<=1; IFID_Misalign<=misalign flag.
- Flush without Redirect: PC advances normally unless Stall=1. With Flush and Stall both set, PC holds and IF/ID takes the bubble.
- Fetch_Count increments by 1, wrapping, on every posedge where IF/ID performs a load. It never increments on bubble or stall cycles.
- All outputs other than Instr_Addr are registered. There are no combinational paths from Stall, Flush or Redirect to any output.

Decomposition:
- Shared package pipe_pkg:
  - WORD_W=32
  - NOP_INSTR=32'h0000_0000
  - the IF/ID struct {instr, pc4, valid, misalign}, reused by the ID stage
- One natural sub-module: ifid_reg, a pipeline register with hold/bubble/load priority, reusable for ID/EX and later stages.
- The PC logic stays in this block.

Test Plan:
- Reset then free-run 3 cycles, memory preloaded with 32'h0022_1820, 32'h2023_0004, 32'h2423_0004 at addresses 0/4/8 -> Instr_Addr 0,4,8,12. IF/ID shows those words with PC4 4,8,12, Valid=1. Fetch_Count=3.
- Stall held 2 cycles while PC=8 -> Instr_Addr stays 8. IF/ID holds 32'h2023_0004/PC4=8. Fetch_Count unchanged. On release, IF/ID loads the word at 8.
- Redirect_en=1, Redirect_Addr=32'h40 while PC=8 -> next PC=0x40, IF/ID bubble (Valid=0, Instr=0). The following cycle loads from 0x40 with PC4=0x44.
- Redirect_en=1 with Stall=1, Redirect_Addr=32'h23 -> PC=0x20, IF/ID bubble. The next load has IFID_Misalign=1; the load after that has Misalign=0.
- Set RESET_PC=32'hFFFF_FFF8 and run 3 cycles -> Instr_Addr FFFF_FFF8, FFFF_FFFC, 0000_0000. IFID_PC4 after the second load = 32'h0000_0000.
- Assert rst_n=0 for one cycle mid-stall with Valid=1 and Fetch_Count=5 -> all registered outputs reset to 0 and PC=RESET_PC, regardless of Stall, Flush and Redirect.
